// File: rtl/seq_mdu.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// state | meaning: IDLE wait for start; CALC one iteration/cycle; FIX sign correction; DONE results valid
module seq_mdu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   MDUctr,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Hi,
    output logic [N-1:0] Lo,
    output logic         Zero,
    output logic         DivZero
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]  cnt;
    logic           op_div;
    logic           neg_q;
    logic           neg_r;
    logic           b_zero;
    logic [N-1:0]   a_raw;
    logic [N-1:0]   b_mag;
    logic [N-1:0]   p_hi;
    logic [N-1:0]   p_lo;

    logic           accept;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_abs;
    logic [N-1:0]   b_abs;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N:0]     div_diff;
    logic           div_ge;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   fix_hi;
    logic [N-1:0]   fix_lo;

    assign accept = start && (state == IDLE || state == DONE);
    assign a_neg  = MDUctr[0] & A[N-1];
    assign b_neg  = MDUctr[0] & B[N-1];
    assign a_abs  = a_neg ? -A : A;
    assign b_abs  = b_neg ? -B : B;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // p_hi holds the running partial product / remainder, p_lo the multiplier / quotient.
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_mag} : '0);
    assign div_shift = {p_hi, p_lo[N-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign prod_fix  = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};

    always_comb begin
        fix_hi = prod_fix[2*N-1:N];
        fix_lo = prod_fix[N-1:0];
        if (op_div) begin
            if (b_zero) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_r ? -p_hi : p_hi;
                fix_lo = neg_q ? -p_lo : p_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
            a_raw   <= '0;
            b_mag   <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            Hi      <= '0;
            Lo      <= '0;
            Zero    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            if (accept) begin
                cnt    <= CW'(N);
                op_div <= MDUctr[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (B == '0);
                a_raw  <= A;
                b_mag  <= b_abs;
                p_hi   <= '0;
                p_lo   <= a_abs;
            end else if (state == CALC) begin
                cnt <= cnt - CW'(1);
                if (op_div) begin
                    p_hi <= div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
                    p_lo <= {p_lo[N-2:0], div_ge};
                end else begin
                    {p_hi, p_lo} <= {mul_sum, p_lo[N-1:1]};
                end
            end
            if (state == FIX) begin
                Hi      <= fix_hi;
                Lo      <= fix_lo;
                Zero    <= (fix_hi == '0) && (fix_lo == '0);
                DivZero <= op_div & b_zero;
            end
        end
    end
endmodule

// File: tb/tb_seq_mdu.sv
// Scoreboard bench for seq_mdu: driver pushes expected results, a negedge monitor checks them.
module tb_seq_mdu;
    localparam int N = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        dz;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    MDUctr;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          busy;
    logic          done;
    logic [N-1:0]  Hi;
    logic [N-1:0]  Lo;
    logic          Zero;
    logic          DivZero;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   busy_from = 0;
    int   busy_until = -1;
    bit   mon_en = 1'b0;
    bit   mon_exp_done;
    exp_t mon_e;
    exp_t sq[$];

    seq_mdu #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .MDUctr(MDUctr), .A(A), .B(B),
        .busy(busy), .done(done), .Hi(Hi), .Lo(Lo), .Zero(Zero), .DivZero(DivZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference results from plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] u;
        e.dz = 1'b0;
        e.cyc = 0;
        case (op)
            2'd0: begin
                u = {32'h0, a} * {32'h0, b};
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            2'd1: begin
                u = longint'($signed(a)) * longint'($signed(b));
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (op == 2'd2) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    sa  = longint'($signed(a));
                    sbv = longint'($signed(b));
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        e.zero = ({e.hi, e.lo} == 64'h0);
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(20));
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_done = (sq.size() > 0) && (sq[0].cyc == cyc);
            check("busy", busy, (cyc >= busy_from) && (cyc <= busy_until));
            check("done", done, mon_exp_done);
            if (mon_exp_done) begin
                mon_e = sq.pop_front();
                check("hi", Hi, mon_e.hi);
                check("lo", Lo, mon_e.lo);
                check("zero", Zero, mon_e.zero);
                check("divzero", DivZero, mon_e.dz);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start for one cycle at the current cycle c; result expected in cycle c+N+2.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        e.cyc = cyc + N + 2;
        sq.push_back(e);
        busy_from  = cyc + 1;
        busy_until = cyc + N + 1;
        start  = 1'b1;
        MDUctr = op;
        A      = a;
        B      = b;
        wait_cycles(1);
        start  = 1'b0;
        MDUctr = 2'($urandom);
        A      = $urandom;
        B      = $urandom;
    endtask

    // Issue and wait until the done cycle; optionally pulse ignored starts while busy.
    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        issue(op, a, b);
        for (int i = 0; i < N + 1; i++) begin
            if (noise) begin
                start  = ($urandom_range(3) == 0);
                MDUctr = 2'($urandom);
                A      = $urandom;
                B      = $urandom;
            end
            wait_cycles(1);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        MDUctr = 2'b00;
        A = '0;
        B = '0;
        wait_cycles(3);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", Hi, 32'h0);
        check("rst_lo", Lo, 32'h0);
        check("rst_zero", Zero, 1'b0);
        check("rst_divzero", DivZero, 1'b0);
        mon_en = 1'b1;

        run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(2'd1, 32'hFFFF_FFF0, 32'h0000_0008, 1'b0);
        run(2'd1, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0);
        run(2'd3, 32'hFFFF_FFEF, 32'h0000_0005, 1'b0);
        run(2'd2, 32'h8000_0001, 32'h0000_0002, 1'b0);
        run(2'd2, 32'h0000_1234, 32'h0000_0000, 1'b0);
        run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run(2'd3, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0);
        wait_cycles(2);

        // Start while busy is ignored; start during the done cycle is accepted.
        issue(2'd0, 32'd3, 32'd4);
        wait_cycles(4);
        start = 1'b1;
        MDUctr = 2'd2;
        A = 32'd9;
        B = 32'd2;
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(28);
        issue(2'd2, 32'd9, 32'd2);
        wait_cycles(N + 1);
        wait_cycles(1);

        // Reset mid-operation abandons it with no done pulse.
        issue(2'd0, 32'd7, 32'd7);
        wait_cycles(9);
        rst = 1'b1;
        sq.delete();
        busy_until = cyc;
        wait_cycles(1);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_hi", Hi, 32'h0);
        check("midrst_lo", Lo, 32'h0);
        check("midrst_zero", Zero, 1'b0);
        wait_cycles(N + 4);
        run(2'd0, 32'd7, 32'd7, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run(2'($urandom_range(3)), rand_operand(), rand_operand(), 1'b1);
            wait_cycles($urandom_range(3));
        end

        wait_cycles(4);
        check("scoreboard_empty", sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
